// File: rtl/adc_frame_packer_pkg.sv
// rtl/adc_frame_packer_pkg.sv - shared ADC/CSI packet definitions
//
// Purpose : FSM state encoding, header byte count and default sync marker
//           shared by the ADC frame packer and its neighbours.
// Ports   : none (package)
package adc_frame_packer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2,
      ST_CSUM = 2'd3
   } state_t;

   // Header = sync word (2 bytes) + sequence number (2 bytes).
   localparam int          HDR_BYTES         = 4;
   localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA55A;

endpackage

// File: rtl/adc_frame_packer.sv
// rtl/adc_frame_packer.sv - packs one multi-channel ADC sample into a byte packet
//
// Purpose : Captures NUM_CH 16-bit channel words on sample_valid&&enable and
//           streams SYNC_WORD, seq, ch1..chN, XOR checksum, low byte first,
//           with a valid/ready handshake on the byte output.
// Ports   : sys_clk      - single clock, rising edge
//           rst          - synchronous active-high reset
//           enable       - capture enable for new samples
//           sample_valid - one-cycle pulse, ADC read complete
//           ch_data      - NUM_CH*16 channel words, channel 1 at [15:0]
//           out_ready    - downstream can accept a byte
//           out_valid    - out_data holds a valid byte
//           out_data     - packet byte
//           out_last     - checksum byte (final byte of packet)
//           busy         - packet in progress
//           drop_cnt     - saturating count of samples lost while busy
module adc_frame_packer
   import adc_frame_packer_pkg::*;
#(
   parameter int          NUM_CH    = 8,
   parameter logic [15:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 sample_valid,
   input  logic [NUM_CH*16-1:0] ch_data,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   output logic                 out_last,
   output logic                 busy,
   output logic [15:0]          drop_cnt
);

   localparam int         DATA_BYTES = 2 * NUM_CH;
   localparam logic [4:0] HDR_LAST   = 5'(HDR_BYTES - 1);
   localparam logic [4:0] DATA_LAST  = 5'(HDR_BYTES + DATA_BYTES - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [4:0]            r_byte_cnt;   // byte index within the packet
   logic [NUM_CH*16-1:0]  r_cap;
   logic [15:0]           r_seq;
   logic [7:0]            r_csum;       // XOR of bytes already transferred
   logic [15:0]           r_drop_cnt;

   logic                  w_xfer;
   logic                  w_capture_req;
   logic                  w_start;
   logic                  w_drop;
   logic [7:0]            w_byte;

   assign out_valid     = (r_state != ST_IDLE);
   assign out_last      = (r_state == ST_CSUM);
   assign out_data      = w_byte;
   assign busy          = out_valid;
   assign drop_cnt      = r_drop_cnt;

   assign w_xfer        = out_valid && out_ready;
   assign w_capture_req = sample_valid && enable;
   // A new sample is taken when idle, or in the very cycle the checksum
   // byte leaves, so back-to-back packets have no gap.
   assign w_start       = w_capture_req &&
                          ((r_state == ST_IDLE) || ((r_state == ST_CSUM) && w_xfer));
   assign w_drop        = w_capture_req && !w_start;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_start) w_state_nxt = ST_HDR;
         ST_HDR:  if (w_xfer && (r_byte_cnt == HDR_LAST)) w_state_nxt = ST_DATA;
         ST_DATA: if (w_xfer && (r_byte_cnt == DATA_LAST)) w_state_nxt = ST_CSUM;
         ST_CSUM: if (w_xfer) w_state_nxt = w_start ? ST_HDR : ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Byte-select mux. Channel bytes are already laid out low byte first in
   // the capture register, so data byte b is simply r_cap byte b.
   always_comb begin
      w_byte = 8'h00;
      case (r_state)
         ST_HDR: begin
            case (r_byte_cnt[1:0])
               2'd0:    w_byte = SYNC_WORD[7:0];
               2'd1:    w_byte = SYNC_WORD[15:8];
               2'd2:    w_byte = r_seq[7:0];
               default: w_byte = r_seq[15:8];
            endcase
         end
         ST_DATA: begin
            for (int b = 0; b < DATA_BYTES; b++) begin
               if (r_byte_cnt == 5'(HDR_BYTES + b)) w_byte = r_cap[b*8 +: 8];
            end
         end
         ST_CSUM: w_byte = r_csum;
         default: w_byte = 8'h00;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_byte_cnt <= 5'd0;
         r_cap      <= '0;
         r_seq      <= 16'd0;
         r_csum     <= 8'h00;
         r_drop_cnt <= 16'd0;
      end else begin
         if (w_start) begin
            r_cap      <= ch_data;
            r_byte_cnt <= 5'd0;
            r_csum     <= 8'h00;
         end else if (w_xfer) begin
            r_byte_cnt <= r_byte_cnt + 5'd1;
            r_csum     <= r_csum ^ w_byte;
         end
         if ((r_state == ST_CSUM) && w_xfer) begin
            r_seq <= r_seq + 16'd1;
         end
         if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb/tb_adc_frame_packer.sv - self-checking bench for adc_frame_packer
module tb_adc_frame_packer;

   logic          sys_clk;
   logic          rst;
   logic          enable;
   logic          sample_valid;
   logic [127:0]  ch_data;
   logic          out_ready;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_last;
   logic          busy;
   logic [15:0]   drop_cnt;

   adc_frame_packer dut (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .enable       (enable),
      .sample_valid (sample_valid),
      .ch_data      (ch_data),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .busy         (busy),
      .drop_cnt     (drop_cnt)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [8:0] q[$];          // {last, data} expected bytes
   logic [15:0] exp_seq = 16'd0;

   typedef struct {
      logic [127:0] ch;
      logic         en;
      logic         tog;
      int           pulse_at;
      logic         pulse_new;
      int           exp_cycles;
      logic [15:0]  exp_drop;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_pkt(input logic [127:0] ch);
      logic [7:0] b [20];
      logic [7:0] cs;
      b[0] = 8'h5A;
      b[1] = 8'hA5;
      b[2] = exp_seq[7:0];
      b[3] = exp_seq[15:8];
      for (int i = 0; i < 16; i++) b[4+i] = ch[i*8 +: 8];
      cs = 8'h00;
      for (int i = 0; i < 20; i++) begin
         cs = cs ^ b[i];
         q.push_back({1'b0, b[i]});
      end
      q.push_back({1'b1, cs});
      exp_seq = exp_seq + 16'd1;
   endtask

   // Scoreboard: every presented byte must match the queue head; it is
   // popped only when the handshake completes at the coming edge.
   always @(negedge sys_clk) begin
      if (out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_byte", {23'd0, out_last, out_data}, 32'h0);
            if (out_last == 1'b0 && out_data == 8'h00) begin
               n_fail++;
               $display("FAIL unexpected_valid: got out_valid=1 expected 0");
            end
         end else begin
            chk("byte", {23'd0, out_last, out_data}, {23'd0, q[0]});
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   task automatic run_vec(input vec_t v);
      int           cycles;
      logic [127:0] p;
      p = {v.ch[63:0], v.ch[127:64]} ^ {8{16'h3C3C}};
      ch_data      = v.ch;
      enable       = v.en;
      sample_valid = 1'b1;
      out_ready    = 1'b1;
      if (v.en) push_pkt(v.ch);
      @(posedge sys_clk); #1;
      sample_valid = 1'b0;
      enable       = 1'b0;
      ch_data      = ~v.ch;
      cycles       = 0;
      while (q.size() > 0 && cycles < 200) begin
         if (cycles + 1 == v.pulse_at) begin
            sample_valid = 1'b1;
            enable       = 1'b1;
            ch_data      = p;
            if (v.pulse_new) push_pkt(p);
         end else begin
            sample_valid = 1'b0;
            enable       = 1'b0;
         end
         @(posedge sys_clk); #1;
         cycles++;
         if (v.tog) out_ready = ~out_ready;
      end
      sample_valid = 1'b0;
      enable       = 1'b0;
      out_ready    = 1'b1;
      chk("packet_cycles", cycles, v.exp_cycles);
      repeat (3) begin
         @(posedge sys_clk); #1;
      end
      chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, v.exp_drop});
      chk("busy_after", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [127:0] ch_a;
      logic [127:0] ch_b;
      vec_t         v;

      for (int i = 0; i < 8; i++) ch_a[i*16 +: 16] = {8'(i + 1), 8'(i + 1)};
      for (int i = 0; i < 8; i++) ch_b[i*16 +: 16] = 16'(32'h1234 * (i + 3) ^ 32'h0F0F);

      vecs[0] = '{ch: ch_a,  en: 1'b1, tog: 1'b0, pulse_at: 0,  pulse_new: 1'b0, exp_cycles: 21, exp_drop: 16'd0};
      vecs[1] = '{ch: ch_a,  en: 1'b1, tog: 1'b1, pulse_at: 0,  pulse_new: 1'b0, exp_cycles: 41, exp_drop: 16'd0};
      vecs[2] = '{ch: ch_b,  en: 1'b1, tog: 1'b0, pulse_at: 10, pulse_new: 1'b0, exp_cycles: 21, exp_drop: 16'd1};
      vecs[3] = '{ch: ~ch_b, en: 1'b1, tog: 1'b0, pulse_at: 21, pulse_new: 1'b1, exp_cycles: 42, exp_drop: 16'd1};
      vecs[4] = '{ch: ch_b,  en: 1'b0, tog: 1'b0, pulse_at: 0,  pulse_new: 1'b0, exp_cycles: 0,  exp_drop: 16'd1};

      rst          = 1'b1;
      enable       = 1'b0;
      sample_valid = 1'b0;
      ch_data      = '0;
      out_ready    = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_last",  {31'd0, out_last},  32'd0);
      chk("rst_out_data",  {24'd0, out_data},  32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_drop_cnt",  {16'd0, drop_cnt},  32'd0);
      rst = 1'b0;

      // enable low: three pulses produce nothing and count nothing
      ch_data = ch_a;
      for (int i = 0; i < 3; i++) begin
         sample_valid = 1'b1;
         @(posedge sys_clk); #1;
         sample_valid = 1'b0;
         @(posedge sys_clk); #1;
      end
      repeat (3) @(posedge sys_clk);
      #1;
      chk("en0_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      chk("en0_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         v = vecs[i];
         run_vec(v);
      end

      // sequence wrap: preload seq to FFFF while idle
      force dut.r_seq = 16'hFFFF;
      @(posedge sys_clk); #1;
      release dut.r_seq;
      exp_seq = 16'hFFFF;
      v = '{ch: ch_b, en: 1'b1, tog: 1'b0, pulse_at: 0, pulse_new: 1'b0, exp_cycles: 21, exp_drop: 16'd1};
      run_vec(v);
      v.ch = ch_a;
      run_vec(v);

      // reset while byte 7 is presented
      ch_data      = ch_b;
      enable       = 1'b1;
      sample_valid = 1'b1;
      push_pkt(ch_b);
      @(posedge sys_clk); #1;
      sample_valid = 1'b0;
      enable       = 1'b0;
      repeat (6) begin
         @(posedge sys_clk); #1;
      end
      rst       = 1'b1;
      out_ready = 1'b0;
      @(posedge sys_clk); #1;
      chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      q.delete();
      exp_seq = 16'd0;
      repeat (2) begin
         @(posedge sys_clk); #1;
      end
      v = '{ch: ch_a, en: 1'b1, tog: 1'b0, pulse_at: 0, pulse_new: 1'b0, exp_cycles: 21, exp_drop: 16'd0};
      run_vec(v);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/adc_frame_packer.md
ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of 16-bit ADC channels per sample.
REQ-002 SHALL have parameter SYNC_WORD, default 16'hA55A, packet sync marker.
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  capture enable for new samples.
REQ-006 SHALL have port sample_valid  input  1  one-cycle pulse, ADC read complete.
REQ-007 SHALL have port ch_data  input  NUM_CH*16  channel words; channel 1 at bits [15:0].
REQ-008 SHALL have port out_ready  input  1  downstream FIFO can accept a byte (not full).
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid byte.
REQ-010 SHALL have port out_data  output  8  packet byte.
REQ-011 SHALL have port out_last  output  1  marks the checksum byte, the final byte of a packet.
REQ-012 SHALL have port busy  output  1  packet in progress (state not IDLE).
REQ-013 SHALL have port drop_cnt  output  16  count of samples lost while busy, saturating.

Function
REQ-014 SHALL build packets of 2*NUM_CH+5 bytes (21 at default), in this order: SYNC_WORD, seq, ch1..chNUM_CH, checksum.
REQ-015 SHALL send every 16-bit field low byte first; at defaults the first two bytes are 8'h5A, 8'hA5.
REQ-016 SHALL make the checksum byte the XOR of all preceding bytes of the same packet.
REQ-017 SHALL use FSM states IDLE, HDR (4 bytes), DATA (2*NUM_CH bytes) and CSUM (1 byte).
REQ-018 SHALL transition IDLE->HDR on sample_valid&&enable, HDR->DATA, DATA->CSUM, and CSUM->IDLE, each transition on acceptance of the last byte of its section.
REQ-019 SHALL register ch_data into a capture register in the cycle sample_valid is accepted; later ch_data changes SHALL NOT affect the packet.
REQ-020 SHALL assert out_valid with the first byte in the cycle after the capturing edge (latency 1 cycle).
REQ-021 SHALL treat a byte as transferred only when out_valid&&out_ready at a rising edge.
REQ-022 SHALL hold out_data and out_last stable while out_valid&&!out_ready, and SHALL never deassert out_valid before that byte is transferred.
REQ-023 SHALL stream one byte per cycle while out_ready stays high (21 cycles per packet at default).
REQ-024 SHALL accept sample_valid in the same cycle the CSUM byte is transferred, starting the next packet with no idle cycle.
REQ-025 SHALL discard sample_valid&&enable arriving at any other time while busy, and SHALL increment drop_cnt, saturating at 16'hFFFF.
REQ-026 SHALL ignore sample_valid while enable is low, without counting a drop.
REQ-027 SHALL let enable falling mid-packet have no effect on the current packet.
REQ-028 SHALL hold seq at 0 for the first packet after reset, increment it by 1 after each CSUM transfer, and wrap from 16'hFFFF to 0.
REQ-029 SHALL hold out_last=1 only while the CSUM byte is presented.

Reset
REQ-030 SHALL, when rst is high at a rising edge, set the FSM to IDLE, out_valid=0, out_last=0, out_data=8'h00, busy=0, drop_cnt=0, seq=0, checksum accumulator=0 and capture register=0.
REQ-031 SHALL abandon a packet in progress on reset with no further bytes emitted; the next sample after rst falls starts a fresh packet with seq=0.

Structure
REQ-032 SHALL keep the FSM state encoding, the header byte count (4) and the default SYNC_WORD in the shared ADC/CSI package.
REQ-033 SHALL instantiate no sub-modules; a byte-select mux indexed by a 5-bit byte counter is internal.

Verification
REQ-034 SHALL cover: rst, then sample_valid with ch1..ch8=16'h0101..16'h0808 and out_ready=1 -> 21 consecutive bytes 5A A5 00 00 01 01 02 02 ... 08 08 CS, out_last on byte 21 only, CS = XOR of the prior 20 bytes.
REQ-035 SHALL cover: out_ready toggled 1/0 every cycle during a packet -> identical byte sequence, each byte stable while stalled, packet takes 41 cycles.
REQ-036 SHALL cover: second sample_valid at byte 10 -> drop_cnt=1 and no packet for that sample; sample_valid coincident with CSUM transfer -> next packet starts next cycle with seq=1.
REQ-037 SHALL cover: seq preloaded by emitting 65536 packets -> packet 65537 carries seq 00 00.
REQ-038 SHALL cover: enable=0 with 3 sample_valid pulses -> no output, drop_cnt=0; rst asserted at byte 7 -> out_valid=0 the next cycle, next packet starts 5A A5 00 00.
